// File: rtl/rv32ima_pkg.sv
// Shared core types: word, load/store width, RAM handshake state and the
// RAM port arbiter's state, owner and latched-request types.
package rv32ima_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned LDST_WIDTH_W = 2;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [LDST_WIDTH_W-1:0] ldst_width_t;

  localparam ldst_width_t LDST_BYTE = 2'd0;
  localparam ldst_width_t LDST_HALF = 2'd1;
  localparam ldst_width_t LDST_WORD = 2'd2;

  typedef enum logic [1:0] {
    RAM_IDLE  = 2'd0,
    RAM_BUSY  = 2'd1,
    RAM_DONE  = 2'd2,
    RAM_ERROR = 2'd3
  } ram_state_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  // Request captured at grant time; drives the RAM port for the whole access.
  typedef struct packed {
    logic        wen;
    word_t       addr;
    word_t       wdata;
    ldst_width_t width;
  } ram_req_t;

endpackage

// File: rtl/ram_port_arbiter_pick.sv
// Combinational grant decision: LSU has priority unless fetch has been
// passed over STARVE_MAX times in a row.
module ram_arb_pick #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          pick_i_c,
  output logic          pick_d_c
);

  always_comb begin
    pick_d_c = d_req && !(if_req && (starve_cnt == SW'(STARVE_MAX)));
    pick_i_c = if_req && !pick_d_c;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single CPU RAM port between instruction fetch and the LSU,
// one transaction at a time, with fetch starvation protection and a timeout.
module ram_port_arbiter
  import rv32ima_pkg::*;
#(
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    if_req,
  input  logic [31:0]             if_addr,
  output logic [31:0]             if_rdata,
  output logic                    if_done,
  output logic                    if_err,
  input  logic                    d_req,
  input  logic                    d_wen,
  input  logic [31:0]             d_addr,
  input  logic [31:0]             d_wdata,
  input  logic [LDST_WIDTH_W-1:0] d_width,
  output logic [31:0]             d_rdata,
  output logic                    d_done,
  output logic                    d_err,
  output logic [31:0]             ram_addr,
  output logic [31:0]             ram_store,
  output logic                    ram_ren,
  output logic                    ram_wen,
  output logic [LDST_WIDTH_W-1:0] ram_width,
  input  logic [31:0]             ram_load,
  input  ram_state_t              ram_state,
  output arb_owner_t              arb_owner
);

  localparam int unsigned SW    = $clog2(STARVE_MAX + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t       state_q, state_d;
  ram_req_t         req_q, req_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ren_d, wen_d;
  arb_owner_t       owner_d;
  logic             if_done_d, if_err_d, d_done_d, d_err_d;
  word_t            if_rdata_d, d_rdata_d;
  logic             pick_i_c, pick_d_c;
  logic             finish_c, resp_err_c;
  word_t            resp_rdata_c;

  ram_arb_pick #(.STARVE_MAX(STARVE_MAX), .SW(SW)) u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_cnt (starve_q),
    .pick_i_c   (pick_i_c),
    .pick_d_c   (pick_d_c)
  );

  // Grant ends on RAM completion, RAM error or the last allowed wait cycle.
  assign finish_c     = (ram_state == RAM_DONE) || (ram_state == RAM_ERROR) ||
                        (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign resp_err_c   = (ram_state != RAM_DONE);
  assign resp_rdata_c = ((ram_state == RAM_DONE) && !req_q.wen) ? ram_load : '0;

  assign ram_addr  = req_q.addr;
  assign ram_store = req_q.wdata;
  assign ram_width = req_q.width;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    ren_d      = ram_ren;
    wen_d      = ram_wen;
    owner_d    = arb_owner;
    if_done_d  = 1'b0;
    if_err_d   = 1'b0;
    if_rdata_d = '0;
    d_done_d   = 1'b0;
    d_err_d    = 1'b0;
    d_rdata_d  = '0;
    unique case (state_q)
      IDLE: begin
        owner_d = OWN_NONE;
        if (!if_req) starve_d = '0;
        if (pick_d_c) begin
          state_d  = GRANT_D;
          owner_d  = OWN_D;
          req_d    = '{wen: d_wen, addr: d_addr, wdata: d_wdata, width: d_width};
          ren_d    = ~d_wen;
          wen_d    = d_wen;
          tmo_d    = '0;
          // Count only grants that made a waiting fetch wait longer.
          if (if_req && (starve_q != SW'(STARVE_MAX))) starve_d = starve_q + SW'(1);
        end else if (pick_i_c) begin
          state_d  = GRANT_I;
          owner_d  = OWN_IF;
          req_d    = '{wen: 1'b0, addr: if_addr, wdata: '0, width: LDST_WORD};
          ren_d    = 1'b1;
          wen_d    = 1'b0;
          tmo_d    = '0;
          starve_d = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (finish_c) begin
          state_d = RESP;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          if (state_q == GRANT_I) begin
            if_done_d  = 1'b1;
            if_err_d   = resp_err_c;
            if_rdata_d = resp_rdata_c;
          end else begin
            d_done_d   = 1'b1;
            d_err_d    = resp_err_c;
            d_rdata_d  = resp_rdata_c;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      starve_q  <= '0;
      tmo_q     <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      arb_owner <= OWN_NONE;
      if_done   <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
      ram_ren   <= ren_d;
      ram_wen   <= wen_d;
      arb_owner <= owner_d;
      if_done   <= if_done_d;
      if_err    <= if_err_d;
      if_rdata  <= if_rdata_d;
      d_done    <= d_done_d;
      d_err     <= d_err_d;
      d_rdata   <= d_rdata_d;
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single CPU-side RAM port (addr/store/load/ren/wen/width/state) between two requesters: instruction fetch (read-only) and the load/store unit (read/write).
- Sits between the fetch and LSU stages and the cpu modport of cpu_ram_if.
- Serialises accesses, holds RAM request signals stable for the whole transaction, and returns read data and a one-cycle done pulse to the winner.
- Provides starvation protection for fetch and a hang timeout.

Parameters:
- STARVE_MAX, 4: consecutive LSU grants allowed while fetch is waiting; the next decision then goes to fetch.
- TIMEOUT_CYC, 256: cycles in a grant state without RAM_DONE/RAM_ERROR before the arbiter aborts with an error.

Ports:
- clk  in  1  core clock
- nrst  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  32  fetch address (word_t)
- if_rdata  out  32  fetched word; valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- if_err  out  1  qualifies if_done; 1 = RAM error or timeout
- d_req  in  1  LSU request; held with d_* until d_done
- d_wen  in  1  1 = store, 0 = load
- d_addr  in  32  LSU address
- d_wdata  in  32  store data
- d_width  in  LDST_WIDTH_W  access width
- d_rdata  out  32  load data; valid while d_done=1
- d_done  out  1  one-cycle completion pulse
- d_err  out  1  qualifies d_done
- ram_addr  out  32  to RAM
- ram_store  out  32  to RAM
- ram_ren  out  1  to RAM
- ram_wen  out  1  to RAM
- ram_width  out  LDST_WIDTH_W  to RAM
- ram_load  in  32  from RAM
- ram_state  in  ram_state_t  RAM_IDLE / RAM_BUSY / RAM_DONE / RAM_ERROR
- arb_owner  out  2  OWN_NONE=0, OWN_IF=1, OWN_D=2 (observability)

Behaviour:
- Clock and reset: clk and nrst. Reset is asynchronous, active-low (nrst).
- Reset state (all outputs and registers): state=IDLE; all outputs 0; starve_cnt=0; tmo_cnt=0.
- States:
  - IDLE: no access in flight.
  - GRANT_I: fetch owns the port.
  - GRANT_D: LSU owns the port.
  - RESP: one-cycle response.
- IDLE decision, registered:
  - d_req only -> GRANT_D.
  - if_req only -> GRANT_I.
  - Both requesting: GRANT_D, unless starve_cnt==STARVE_MAX, then GRANT_I.
  - Request fields are latched into internal registers on the transition.
- starve_cnt:
  - Increments on each LSU grant made while if_req=1, saturating at STARVE_MAX.
  - Clears on any fetch grant, and in IDLE whenever if_req=0.
- GRANT_I: ram_ren=1, ram_wen=0, ram_width=LDST_WORD, ram_addr=latched if_addr, ram_store=0.
- GRANT_D: ram_ren=~wen, ram_wen=wen, plus latched addr, width and wdata.
- Outputs in GRANT states are driven from latched registers, so they stay stable even if the requester misbehaves.
- Leaving a GRANT state, checked every GRANT cycle:
  - ram_state==RAM_DONE -> capture ram_load into the rdata register, err=0, go to RESP.
  - ram_state==RAM_ERROR -> err=1, go to RESP.
  - Neither, and tmo_cnt==TIMEOUT_CYC-1 -> err=1, rdata=0, go to RESP.
  - Otherwise tmo_cnt increments.
  - tmo_cnt clears on GRANT entry.
- RESP:
  - Exactly one cycle.
  - ram_ren=ram_wen=0.
  - Owner's done=1 with rdata/err valid; the other requester's done=0.
  - Next state is always IDLE.
- Requester contract: req is deasserted in the cycle done is seen, or kept high to issue a new request, which is re-arbitrated in IDLE.
- Minimum transaction time: 1 (IDLE) + RAM latency + 1 (RESP) cycles.
- Store rdata: don't-care, driven 0.
- arb_owner tracks the GRANT/RESP owner; it is OWN_NONE in IDLE.
- Reset mid-transaction:
  - Aborts immediately; ram_ren/wen drop asynchronously.
  - No done pulse is produced; the requester re-issues after reset.
- Requests arriving during GRANT or RESP wait; a request is never dropped while req is held.

Decomposition:
- Add to rv32ima_pkg:
  - arb_state_t (IDLE, GRANT_I, GRANT_D, RESP).
  - arb_owner_t (OWN_NONE, OWN_IF, OWN_D).
  - LDST_WORD constant, if not already present.
- ram_state_t and LDST_WIDTH_W are already in the package.
- One natural sub-module: ram_arb_pick, a combinational priority/starvation decision, unit-testable alone.
- FSM, latches and timeout live in the top module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; RAM returns DONE after 3 cycles with load 0xDEADBEEF -> ram_ren=1 for 3 cycles, if_done pulses once with if_rdata=0xDEADBEEF, if_err=0.
- Simultaneous requests: if_req=d_req=1, d_wen=1, d_addr=0x200, d_wdata=0x12345678, byte width -> LSU served first (ram_wen=1, ram_store=0x12345678), then fetch; arb_owner sequence 2 then 1.
- Starvation: d_req held for 6 back-to-back loads while if_req=1 and STARVE_MAX=4 -> 4 LSU grants, then a fetch grant, then LSU resumes.
- RAM error: RAM returns RAM_ERROR on an LSU load -> d_done=1 with d_err=1, d_rdata=0; next IDLE decision proceeds normally.
- Timeout: TIMEOUT_CYC=8, RAM stays RAM_BUSY -> after 8 grant cycles, if_done=1 with if_err=1 and ram_ren drops.
- Mid-operation reset: nrst pulsed low in cycle 2 of GRANT_D -> ram_wen=0 asynchronously, no d_done pulse, state IDLE; the re-issued request completes correctly.
